// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs a req/ack fetch port and feeds IF/ID.
// Optional IF_STAGE_PERF_EN adds fetch/stall performance counters.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out
`ifdef IF_STAGE_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        KILL  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   redir_addr;
    logic [XLEN-1:0]   hold_instr;
    logic [XLEN-1:0]   pc_inc;
    logic [XLEN-1:0]   branch_tgt;
    logic              consume;

    assign pc_inc     = pc + PC_STEP;
    assign branch_tgt = branch_addr & WORD_MASK;

    // Presentation to IF/ID is combinational so zero-wait memory sustains one word per clock.
    always_comb begin
        imem_req        = 1'b0;
        imem_addr       = pc & WORD_MASK;
        pc_out          = pc_inc;
        valid_out       = 1'b0;
        consume         = 1'b0;
        instruction_out = '0;
        case (state)
            FETCH: begin
                imem_req  = 1'b1;
                valid_out = imem_ack && !branch_taken;
                consume   = imem_ack && !branch_taken && !freeze;
            end
            KILL: begin
                imem_req = 1'b1;
            end
            HOLD: begin
                valid_out = 1'b1;
                consume   = !branch_taken && !freeze;
            end
            default: ;
        endcase
        if (rst) begin
            imem_req  = 1'b0;
            valid_out = 1'b0;
            consume   = 1'b0;
        end
        if (valid_out) begin
            instruction_out = (state == HOLD) ? hold_instr : imem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            redir_addr <= '0;
            hold_instr <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        if (branch_taken) begin
                            pc <= branch_tgt;
                        end else if (!freeze) begin
                            pc <= pc_inc;
                        end else begin
                            hold_instr <= imem_rdata;
                            state      <= HOLD;
                        end
                    end else if (branch_taken) begin
                        redir_addr <= branch_tgt;
                        state      <= KILL;
                    end
                end
                // Stale request must still complete; the newest redirect target wins.
                KILL: begin
                    if (imem_ack) begin
                        pc    <= branch_taken ? branch_tgt : redir_addr;
                        state <= FETCH;
                    end else if (branch_taken) begin
                        redir_addr <= branch_tgt;
                    end
                end
                HOLD: begin
                    if (branch_taken) begin
                        pc    <= branch_tgt;
                        state <= FETCH;
                    end else if (!freeze) begin
                        pc    <= pc_inc;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

`ifdef IF_STAGE_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (consume) begin
                perf_fetch_cnt <= perf_fetch_cnt + XLEN'(1);
            end
            if (!valid_out || (state == HOLD && freeze)) begin
                perf_stall_cnt <= perf_stall_cnt + XLEN'(1);
            end
        end
    end
`endif

endmodule
